// File: rtl/wb_write_arbiter.sv
// Write-side front end of the register file: arbitrates ALU/load writebacks into a small FIFO
// and retires one write per cycle, reporting pending writes to decode for stall detection.
module wb_write_arbiter #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_dest,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        ld_valid,
  input  logic [4:0]  ld_dest,
  input  logic [31:0] ld_data,
  output logic        ld_ready,
  input  logic        wb_hold,
  input  logic [4:0]  src1,
  input  logic [4:0]  src2,
  output logic        busy1,
  output logic        busy2,
  output logic        reg_write,
  output logic [4:0]  dest,
  output logic [31:0] write_data
);

  localparam logic [AW:0]   FullCount = DEPTH[AW:0];
  localparam logic [AW:0]   CountOne  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PtrOne    = {{(AW-1){1'b0}}, 1'b1};

  logic [4:0]       mem_dest_q [DEPTH];
  logic [31:0]      mem_data_q [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;

  logic        full, accept, push, pop;
  logic [4:0]  push_dest;
  logic [31:0] push_data;

  // Load has fixed priority; ready never looks at the same-cycle pop.
  always_comb begin
    full      = (count_q == FullCount);
    ld_ready  = !full;
    alu_ready = !full && !ld_valid;
    accept    = (ld_valid && ld_ready) || (alu_valid && alu_ready);
    push_dest = ld_valid ? ld_dest : alu_dest;
    push_data = ld_valid ? ld_data : alu_data;
    // x0 writes complete the handshake but are never queued.
    push      = accept && (push_dest != 5'd0);
    pop       = (count_q != '0) && !wb_hold;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    if (pop) begin
      rd_ptr_d          = rd_ptr_q + PtrOne;
      valid_d[rd_ptr_q] = 1'b0;
    end
    if (push) begin
      wr_ptr_d          = wr_ptr_q + PtrOne;
      valid_d[wr_ptr_q] = 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + CountOne;
    end else if (pop && !push) begin
      count_d = count_q - CountOne;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  // Payload storage needs no reset: it is only observed through valid_q/count_q.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      mem_dest_q[wr_ptr_q] <= push_dest;
      mem_data_q[wr_ptr_q] <= push_data;
    end
  end

  always_comb begin
    reg_write  = (count_q != '0) && !wb_hold;
    dest       = 5'd0;
    write_data = 32'd0;
    if (count_q != '0) begin
      dest       = mem_dest_q[rd_ptr_q];
      write_data = mem_data_q[rd_ptr_q];
    end
  end

  always_comb begin
    busy1 = 1'b0;
    busy2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (mem_dest_q[i] == src1)) busy1 = 1'b1;
      if (valid_q[i] && (mem_dest_q[i] == src2)) busy2 = 1'b1;
    end
    busy1 = busy1 && (src1 != 5'd0);
    busy2 = busy2 && (src2 != 5'd0);
  end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter: reset, single write, contention, full/hold,
// x0 drop and mid-queue reset, with hand-computed expectations.
module tb_wb_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, ld_valid, wb_hold;
  logic [4:0]  alu_dest, ld_dest, src1, src2;
  logic [31:0] alu_data, ld_data;
  logic        alu_ready, ld_ready, busy1, busy2, reg_write;
  logic [4:0]  dest;
  logic [31:0] write_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_write_arbiter #(.DEPTH(4), .AW(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_valid  (alu_valid),
    .alu_dest   (alu_dest),
    .alu_data   (alu_data),
    .alu_ready  (alu_ready),
    .ld_valid   (ld_valid),
    .ld_dest    (ld_dest),
    .ld_data    (ld_data),
    .ld_ready   (ld_ready),
    .wb_hold    (wb_hold),
    .src1       (src1),
    .src2       (src2),
    .busy1      (busy1),
    .busy2      (busy2),
    .reg_write  (reg_write),
    .dest       (dest),
    .write_data (write_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; wb_hold = 1'b0;
    alu_valid = 1'b1; alu_dest = 5'd6; alu_data = 32'h6;
    ld_valid = 1'b1;  ld_dest = 5'd7;  ld_data = 32'h7;
    src1 = 5'd7; src2 = 5'd6;

    // 1 reset with offers present
    step(); step();
    chk("rst_reg_write", reg_write, 0);
    chk("rst_busy1", busy1, 0);
    chk("rst_busy2", busy2, 0);
    chk("rst_ld_ready", ld_ready, 1);
    chk("rst_alu_ready", alu_ready, 0);
    chk("rst_dest", dest, 0);
    chk("rst_wdata", write_data, 0);
    rst = 1'b1; alu_valid = 1'b0; ld_valid = 1'b0;
    step();
    chk("post_rst_reg_write", reg_write, 0);
    chk("post_rst_alu_ready", alu_ready, 1);

    // 2 single ALU write
    alu_valid = 1'b1; alu_dest = 5'd5; alu_data = 32'hDEADBEEF; src1 = 5'd5;
    #1;
    chk("single_busy_excl_input", busy1, 0);
    step();
    alu_valid = 1'b0;
    #1;
    chk("single_reg_write", reg_write, 1);
    chk("single_dest", dest, 5);
    chk("single_wdata", write_data, 32'hDEADBEEF);
    chk("single_busy1", busy1, 1);
    step();
    chk("single_busy1_after", busy1, 0);
    chk("single_idle", reg_write, 0);

    // 3 contention: load wins, ALU follows
    ld_valid = 1'b1;  ld_dest = 5'd3;  ld_data = 32'd1;
    alu_valid = 1'b1; alu_dest = 5'd4; alu_data = 32'd2;
    #1;
    chk("cont_ld_ready", ld_ready, 1);
    chk("cont_alu_ready", alu_ready, 0);
    step();
    ld_valid = 1'b0;
    #1;
    chk("cont_alu_ready2", alu_ready, 1);
    chk("cont_w1_en", reg_write, 1);
    chk("cont_w1_dest", dest, 3);
    chk("cont_w1_data", write_data, 1);
    step();
    alu_valid = 1'b0;
    #1;
    chk("cont_w2_en", reg_write, 1);
    chk("cont_w2_dest", dest, 4);
    chk("cont_w2_data", write_data, 2);
    step();
    chk("cont_idle", reg_write, 0);

    // 4 fill under hold, 5th offer stalls, then drain in order
    wb_hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      ld_valid = 1'b1; ld_dest = 5'(i); ld_data = 32'(100 + i);
      #1;
      chk("fill_ld_ready", ld_ready, 1);
      step();
    end
    ld_dest = 5'd5; ld_data = 32'd105; src1 = 5'd4; src2 = 5'd1;
    #1;
    chk("full_ld_ready", ld_ready, 0);
    chk("full_alu_ready", alu_ready, 0);
    chk("hold_reg_write", reg_write, 0);
    chk("hold_dest", dest, 1);
    chk("full_busy1", busy1, 1);
    chk("full_busy2", busy2, 1);
    step();
    chk("stall_ld_ready", ld_ready, 0);
    wb_hold = 1'b0;
    #1;
    chk("nobypass_ld_ready", ld_ready, 0);
    chk("drain1_en", reg_write, 1);
    chk("drain1_dest", dest, 1);
    chk("drain1_data", write_data, 101);
    step();
    chk("drain_ld_ready", ld_ready, 1);
    chk("drain2_dest", dest, 2);
    chk("drain2_data", write_data, 102);
    step();
    ld_valid = 1'b0;
    #1;
    chk("drain3_dest", dest, 3);
    chk("drain_busy2_gone", busy2, 0);
    step();
    chk("drain4_dest", dest, 4);
    chk("drain4_data", write_data, 104);
    step();
    chk("fifth_en", reg_write, 1);
    chk("fifth_dest", dest, 5);
    chk("fifth_data", write_data, 105);
    step();
    chk("drain_idle", reg_write, 0);

    // 5 x0 writes are dropped
    ld_valid = 1'b1; ld_dest = 5'd0; ld_data = 32'hFFFFFFFF; src1 = 5'd0;
    #1;
    chk("x0_ld_ready", ld_ready, 1);
    step();
    ld_valid = 1'b0;
    #1;
    chk("x0_reg_write", reg_write, 0);
    chk("x0_busy1", busy1, 0);
    step();
    chk("x0_reg_write2", reg_write, 0);

    // 6 reset discards a queued backlog
    wb_hold = 1'b1; src1 = 5'd8;
    for (int i = 7; i <= 9; i++) begin
      ld_valid = 1'b1; ld_dest = 5'(i); ld_data = 32'(i);
      step();
    end
    ld_valid = 1'b0;
    #1;
    chk("q3_dest", dest, 7);
    chk("q3_busy1", busy1, 1);
    rst = 1'b0;
    step();
    rst = 1'b1; wb_hold = 1'b0;
    #1;
    chk("midrst_reg_write", reg_write, 0);
    chk("midrst_dest", dest, 0);
    chk("midrst_busy1", busy1, 0);
    step();
    chk("midrst_reg_write2", reg_write, 0);
    alu_valid = 1'b1; alu_dest = 5'd10; alu_data = 32'hA5A5A5A5;
    step();
    alu_valid = 1'b0;
    #1;
    chk("after_rst_en", reg_write, 1);
    chk("after_rst_dest", dest, 10);
    chk("after_rst_data", write_data, 32'hA5A5A5A5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
